// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, Status bit
// positions and the exception/ERET sequencer state encoding.
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_t;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_EXC_WR_ST    = 4'd1,
    S_EXC_WR_CAUSE = 4'd2,
    S_EXC_WR_EPC   = 4'd3,
    S_EXC_WR_BADV  = 4'd4,
    S_ERET_RD_EPC  = 4'd5,
    S_ERET_WR_ST   = 4'd6,
    S_DONE         = 4'd7
  } state_t;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer feeding the CP0 register file one write per cycle.
// Build option CP0_EXC_INT_EN enables hardware interrupt requests and Cause.IP.
//
// state          | meaning
// S_IDLE         | waiting; Status on read port
// S_EXC_WR_ST    | write Status with EXL set
// S_EXC_WR_CAUSE | write Cause (BD, IP, ExcCode)
// S_EXC_WR_EPC   | write EPC (skipped when EXL already set)
// S_EXC_WR_BADV  | write BadVAddr (address errors only)
// S_ERET_RD_EPC  | read EPC into epc_q
// S_ERET_WR_ST   | write Status with EXL cleared
// S_DONE         | one-cycle flush/redirect
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [PC_WIDTH-1:0] exc_pc,
  input  logic                exc_bd,
  input  logic [PC_WIDTH-1:0] exc_badvaddr,
  input  logic                eret_valid,
  input  logic [5:0]          hw_int,
  input  logic [31:0]         cp0_rdata,
  output logic [4:0]          cp0_raddr,
  output logic [4:0]          cp0_waddr,
  output logic                cp0_wen,
  output logic [31:0]         cp0_wdata,
  output logic [2:0]          cp0_sel,
  output logic                busy,
  output logic                flush_valid,
  output logic [PC_WIDTH-1:0] flush_pc
);

`ifdef CP0_EXC_INT_EN
  localparam logic INT_ON = 1'b1;
`else
  localparam logic INT_ON = 1'b0;
`endif

  state_t              state, state_n;
  logic [4:0]          code_q, code_n;
  logic [PC_WIDTH-1:0] pc_q, pc_n, badv_q, badv_n, epc_q, epc_n;
  logic                bd_q, bd_n, eret_q, eret_n;
  logic [31:0]         status_q, status_n;
  logic                int_req;
  logic [5:0]          ip;
  logic                wen_n, flush_n;
  logic [4:0]          waddr_n;
  logic [31:0]         wdata_n;
  logic [PC_WIDTH-1:0] fpc_n;

  assign cp0_sel   = 3'b000;
  assign cp0_raddr = (state == S_ERET_RD_EPC) ? CP0_EPC : CP0_STATUS;

  always_comb begin
    state_n  = state;
    code_n   = code_q;
    pc_n     = pc_q;
    bd_n     = bd_q;
    badv_n   = badv_q;
    status_n = status_q;
    epc_n    = epc_q;
    eret_n   = eret_q;
    int_req  = INT_ON & (|(hw_int & cp0_rdata[15:10])) & cp0_rdata[STATUS_IE]
               & ~cp0_rdata[STATUS_EXL];
    ip       = INT_ON ? hw_int : 6'b0;

    case (state)
      S_IDLE: begin
        if (exc_valid) begin
          code_n   = exc_code;
          pc_n     = exc_pc;
          bd_n     = exc_bd;
          badv_n   = exc_badvaddr;
          status_n = cp0_rdata;
          eret_n   = 1'b0;
          state_n  = S_EXC_WR_ST;
        end else if (eret_valid) begin
          status_n = cp0_rdata;
          eret_n   = 1'b1;
          state_n  = S_ERET_RD_EPC;
        end else if (int_req) begin
          code_n   = EXC_INT;
          pc_n     = exc_pc;
          bd_n     = exc_bd;
          status_n = cp0_rdata;
          eret_n   = 1'b0;
          state_n  = S_EXC_WR_ST;
        end
      end
      S_EXC_WR_ST:    state_n = S_EXC_WR_CAUSE;
      S_EXC_WR_CAUSE: begin
        if (!status_q[STATUS_EXL]) state_n = S_EXC_WR_EPC;
        else if (is_addr_err(code_q)) state_n = S_EXC_WR_BADV;
        else state_n = S_DONE;
      end
      S_EXC_WR_EPC:   state_n = is_addr_err(code_q) ? S_EXC_WR_BADV : S_DONE;
      S_EXC_WR_BADV:  state_n = S_DONE;
      S_ERET_RD_EPC: begin
        epc_n   = cp0_rdata[PC_WIDTH-1:0];
        state_n = S_ERET_WR_ST;
      end
      S_ERET_WR_ST:   state_n = S_DONE;
      S_DONE:         state_n = S_IDLE;
      default:        state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the cycle the FSM spends in that state.
    wen_n   = 1'b0;
    waddr_n = 5'd0;
    wdata_n = 32'd0;
    flush_n = 1'b0;
    fpc_n   = '0;
    case (state_n)
      S_EXC_WR_ST: begin
        wen_n   = 1'b1;
        waddr_n = CP0_STATUS;
        wdata_n = status_n | (32'h1 << STATUS_EXL);
      end
      S_EXC_WR_CAUSE: begin
        wen_n   = 1'b1;
        waddr_n = CP0_CAUSE;
        wdata_n = {bd_n, 15'b0, ip, 3'b0, code_n, 2'b0};
      end
      S_EXC_WR_EPC: begin
        wen_n   = 1'b1;
        waddr_n = CP0_EPC;
        wdata_n = 32'(bd_n ? (pc_n - PC_WIDTH'(4)) : pc_n);
      end
      S_EXC_WR_BADV: begin
        wen_n   = 1'b1;
        waddr_n = CP0_BADVADDR;
        wdata_n = 32'(badv_n);
      end
      S_ERET_WR_ST: begin
        wen_n   = 1'b1;
        waddr_n = CP0_STATUS;
        wdata_n = status_n & ~(32'h1 << STATUS_EXL);
      end
      S_DONE: begin
        flush_n = 1'b1;
        fpc_n   = eret_n ? epc_n : EXC_VECTOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      code_q      <= 5'd0;
      pc_q        <= '0;
      bd_q        <= 1'b0;
      badv_q      <= '0;
      status_q    <= 32'd0;
      epc_q       <= '0;
      eret_q      <= 1'b0;
      busy        <= 1'b0;
      cp0_wen     <= 1'b0;
      cp0_waddr   <= 5'd0;
      cp0_wdata   <= 32'd0;
      flush_valid <= 1'b0;
      flush_pc    <= '0;
    end else begin
      state       <= state_n;
      code_q      <= code_n;
      pc_q        <= pc_n;
      bd_q        <= bd_n;
      badv_q      <= badv_n;
      status_q    <= status_n;
      epc_q       <= epc_n;
      eret_q      <= eret_n;
      busy        <= (state_n != S_IDLE);
      cp0_wen     <= wen_n;
      cp0_waddr   <= waddr_n;
      cp0_wdata   <= wdata_n;
      flush_valid <= flush_n;
      flush_pc    <= fpc_n;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with a small CP0 register file model on its ports.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] EPC_SENT  = 32'hEEEE_EEEE;
  localparam logic [31:0] BADV_SENT = 32'hBBBB_BBBB;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_bd, eret_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata, cp0_wdata, flush_pc;
  logic [4:0]  cp0_raddr, cp0_waddr;
  logic        cp0_wen, busy, flush_valid;
  logic [2:0]  cp0_sel;

  logic [31:0] regs [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
    .eret_valid(eret_valid), .hw_int(hw_int), .cp0_rdata(cp0_rdata),
    .cp0_raddr(cp0_raddr), .cp0_waddr(cp0_waddr), .cp0_wen(cp0_wen),
    .cp0_wdata(cp0_wdata), .cp0_sel(cp0_sel), .busy(busy),
    .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  assign cp0_rdata = regs[cp0_raddr];

  always @(posedge clk) begin
    if (cp0_wen) regs[cp0_waddr] <= cp0_wdata;
    else if (pl_en) regs[pl_addr] <= pl_data;
  end

  typedef struct {
    string       name;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badv;
    logic [31:0] status;
    logic [31:0] exp_status;
    logic [31:0] exp_cause;
    logic [31:0] exp_epc;
    logic [31:0] exp_badv;
    int          exp_writes;
    int          exp_flush;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic setup_regs(input logic [31:0] status);
    preload(5'd12, status);
    preload(5'd13, 32'd0);
    preload(5'd14, EPC_SENT);
    preload(5'd8, BADV_SENT);
  endtask

  // Pulse a request, then count writes and find the flush cycle k (k=1 is the
  // first cycle after the accepting edge). fk stays 0 if no flush shows up.
  task automatic run_seq(input logic ev, input logic rv, input logic [4:0] code,
                         input logic [31:0] pc, input logic bd, input logic [31:0] badv,
                         output int nwr, output int fk, output logic [31:0] fpc,
                         output logic busy1);
    @(negedge clk);
    exc_valid = ev; eret_valid = rv; exc_code = code; exc_pc = pc;
    exc_bd = bd; exc_badvaddr = badv;
    @(posedge clk);
    #1 exc_valid = 1'b0; eret_valid = 1'b0;
    nwr = 0; fk = 0; fpc = 32'd0; busy1 = 1'b0;
    for (int k = 1; k <= 12 && fk == 0; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (cp0_wen) nwr++;
      if (flush_valid) begin fk = k; fpc = flush_pc; end
    end
  endtask

  initial begin
    int nwr, fk, extra;
    logic [31:0] fpc;
    logic b1;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst = 1'b1; exc_valid = 1'b0; eret_valid = 1'b0; exc_code = 5'd0;
    exc_pc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0; hw_int = 6'd0;

    //           name       code  pc            bd    badv          status        st            cause         epc           badv          wr fl
    vecs[0] = '{"sys",      5'd8, 32'h0000_1000, 1'b0, 32'h0,        32'h0000FF01, 32'h0000FF03, 32'h0000_0020, 32'h0000_1000, BADV_SENT,   3, 4};
    vecs[1] = '{"adel_bd",  5'd4, 32'h0000_2004, 1'b1, 32'h0000_3001, 32'h0000FF01, 32'h0000FF03, 32'h8000_0010, 32'h0000_2000, 32'h0000_3001, 4, 5};
    vecs[2] = '{"nested",   5'd12, 32'h0000_5000, 1'b0, 32'h0,       32'h0000_0003, 32'h0000_0003, 32'h0000_0030, EPC_SENT,     BADV_SENT,   2, 3};
    vecs[3] = '{"ades",     5'd5, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0002, 32'h0000_0014, 32'h0000_0000, 32'hFFFF_FFFC, 4, 5};
    vecs[4] = '{"bd_wrap",  5'd10, 32'h0000_0000, 1'b1, 32'h0,       32'h0000_0000, 32'h0000_0002, 32'h8000_0028, 32'hFFFF_FFFC, BADV_SENT,   3, 4};
    vecs[5] = '{"nest_adel",5'd4, 32'h0000_6000, 1'b0, 32'h0000_7000, 32'h0000_0003, 32'h0000_0003, 32'h0000_0010, EPC_SENT,     32'h0000_7000, 3, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush", {31'd0, flush_valid}, 32'd0);
    chk("rst_wen", {31'd0, cp0_wen}, 32'd0);
    chk("rst_wdata", cp0_wdata, 32'd0);
    chk("rst_waddr", {27'd0, cp0_waddr}, 32'd0);
    chk("rst_fpc", flush_pc, 32'd0);
    chk("rst_raddr", {27'd0, cp0_raddr}, 32'd12);
    chk("rst_sel", {29'd0, cp0_sel}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      setup_regs(vecs[i].status);
      run_seq(1'b1, 1'b0, vecs[i].code, vecs[i].pc, vecs[i].bd, vecs[i].badv, nwr, fk, fpc, b1);
      @(negedge clk);
      chk({vecs[i].name, "_busy"}, {31'd0, b1}, 32'd1);
      chk({vecs[i].name, "_status"}, regs[12], vecs[i].exp_status);
      chk({vecs[i].name, "_cause"}, regs[13], vecs[i].exp_cause);
      chk({vecs[i].name, "_epc"}, regs[14], vecs[i].exp_epc);
      chk({vecs[i].name, "_badv"}, regs[8], vecs[i].exp_badv);
      chk({vecs[i].name, "_writes"}, nwr, vecs[i].exp_writes);
      chk({vecs[i].name, "_flush_cyc"}, fk, vecs[i].exp_flush);
      chk({vecs[i].name, "_flush_pc"}, fpc, VEC);
      chk({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
    end

    // ERET
    setup_regs(32'h0000_0003);
    preload(5'd14, 32'h0000_4000);
    run_seq(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 32'd0, nwr, fk, fpc, b1);
    @(negedge clk);
    chk("eret_busy", {31'd0, b1}, 32'd1);
    chk("eret_status", regs[12], 32'h0000_0001);
    chk("eret_writes", nwr, 1);
    chk("eret_flush_cyc", fk, 3);
    chk("eret_flush_pc", fpc, 32'h0000_4000);

    // Simultaneous exc+eret, then a second request while busy
    setup_regs(32'h0000FF01);
    @(negedge clk);
    exc_valid = 1'b1; eret_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h100; exc_bd = 1'b0;
    @(posedge clk);
    #1 exc_valid = 1'b0; eret_valid = 1'b0;
    nwr = 0; fk = 0; fpc = 32'd0;
    for (int k = 1; k <= 12 && fk == 0; k++) begin
      @(negedge clk);
      if (cp0_wen) nwr++;
      if (flush_valid) begin fk = k; fpc = flush_pc; end
      if (k == 1) begin exc_valid = 1'b1; eret_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h200; end
      if (k == 2) begin exc_valid = 1'b0; eret_valid = 1'b0; end
    end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cp0_wen || flush_valid) extra++;
    end
    chk("both_writes", nwr, 3);
    chk("both_flush_cyc", fk, 4);
    chk("both_flush_pc", fpc, VEC);
    chk("both_cause", regs[13], 32'h0000_0020);
    chk("both_epc", regs[14], 32'h0000_0100);
    chk("busy_ignored", extra, 0);
    chk("both_idle", {31'd0, busy}, 32'd0);

    // Reset during EXC_WR_CAUSE
    setup_regs(32'h0000FF01);
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h300;
    @(posedge clk);
    #1 exc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_waddr_cause", {27'd0, cp0_waddr}, 32'd13);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_wen", {31'd0, cp0_wen}, 32'd0);
    chk("rstmid_flush", {31'd0, flush_valid}, 32'd0);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cp0_wen || flush_valid || busy) extra++;
    end
    chk("rstmid_quiet", extra, 0);
    chk("rstmid_epc", regs[14], EPC_SENT);

`ifdef CP0_EXC_INT_EN
    setup_regs(32'h0000_0401);
    @(negedge clk);
    exc_pc = 32'h0000_8000; exc_bd = 1'b0; hw_int = 6'b000001;
    fk = 0; fpc = 32'd0; nwr = 0;
    for (int k = 1; k <= 12 && fk == 0; k++) begin
      @(negedge clk);
      if (cp0_wen) nwr++;
      if (flush_valid) begin fk = k; fpc = flush_pc; end
    end
    hw_int = 6'd0;
    @(negedge clk);
    chk("int_flush_seen", {31'd0, fk != 0}, 32'd1);
    chk("int_flush_pc", fpc, VEC);
    chk("int_cause", regs[13], 32'h0000_0400);
    chk("int_status", regs[12], 32'h0000_0403);
    chk("int_epc", regs[14], 32'h0000_8000);
    chk("int_writes", nwr, 3);
`else
    setup_regs(32'h0000_0401);
    @(negedge clk);
    hw_int = 6'b111111;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cp0_wen || flush_valid || busy) extra++;
    end
    hw_int = 6'd0;
    chk("noint_quiet", extra, 0);
    chk("noint_status", regs[12], 32'h0000_0401);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
